// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg -- shared types and constants for the hiscore RAM arbiter.
//   hs_arb_state_e : arbiter FSM states
//   CNT_W          : width of the shared guard/watchdog down-counter
//   HS_ARB_*_DEF   : default values for the top-level parameters
package hs_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VBL = 3'd1,
        PAUSE    = 3'd2,
        GRANT    = 3'd3,
        RELEASE  = 3'd4
    } hs_arb_state_e;

    localparam int CNT_W = 16;

    localparam int HS_ARB_AW_DEF       = 16;
    localparam int HS_ARB_DW_DEF       = 8;
    localparam int HS_ARB_RELEASE_DEF  = 4;
    localparam int HS_ARB_WDOG_DEF     = 65535;

endpackage

// File: rtl/hs_arb_timer.sv
// hs_arb_timer -- loadable down-counter with a terminal flag.
//   clk_sys, reset_n : clock, async active-low reset
//   load, load_val   : load the counter (has priority over dec)
//   dec              : decrement by one, saturating at zero
//   tc               : counter currently holds 1 (last cycle of the interval)
module hs_arb_timer
    import hs_arb_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter -- shares the core work-RAM port between the CPU and
// the hiscore save/restore engine. A hiscore request waits for vblank,
// pauses the CPU, waits for the pause acknowledge, hands the RAM port to the
// hiscore engine, then holds the pause for RELEASE_CYCLES after the grant.
//   clk_sys, reset_n          : clock, async active-low reset
//   vblank                    : vertical blank level
//   cpu_addr/din/we, cpu_dout : CPU RAM side
//   hs_req, hs_addr/din/we    : hiscore engine side; hs_dout read data
//   hs_grant                  : hiscore owns the RAM port
//   hs_err                    : one-cycle pulse on watchdog abort
//   pause_req, cpu_paused     : pause handshake with the pause block
//   ram_addr/din/we, ram_dout : RAM port (one-cycle read latency)
// Optional: define HS_ARB_WDOG_EN to abort a PAUSE that is never
// acknowledged within WDOG_CYCLES.
module hiscore_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW             = HS_ARB_AW_DEF,
    parameter int DW             = HS_ARB_DW_DEF,
    parameter int RELEASE_CYCLES = HS_ARB_RELEASE_DEF,
    parameter int WDOG_CYCLES    = HS_ARB_WDOG_DEF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_din,
    input  logic          hs_we,
    output logic [DW-1:0] hs_dout,
    output logic          hs_grant,
    output logic          hs_err,
    output logic          pause_req,
    input  logic          cpu_paused,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    hs_arb_state_e    state_q;
    hs_arb_state_e    state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_tc;
    logic             start_ok;
    logic             abort;

    // One timer serves both the release guard and the pause watchdog; they
    // never overlap because the watchdog only runs in PAUSE.
    hs_arb_timer u_timer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

`ifdef HS_ARB_WDOG_EN
    // blocked_q: set by an abort, cleared once hs_req is seen low, so a
    // request stuck high cannot restart the sequence.
    logic blocked_q, blocked_d;
    logic hs_err_q, hs_err_d;

    always_comb begin
        blocked_d = blocked_q;
        if (abort) begin
            blocked_d = 1'b1;
        end else if (!hs_req) begin
            blocked_d = 1'b0;
        end
        hs_err_d = abort;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            blocked_q <= 1'b0;
            hs_err_q  <= 1'b0;
        end else begin
            blocked_q <= blocked_d;
            hs_err_q  <= hs_err_d;
        end
    end

    assign start_ok = !blocked_q;
    assign hs_err   = hs_err_q;
`else
    assign start_ok = 1'b1;
    assign hs_err   = 1'b0;

    // WDOG_CYCLES has no effect in this build; a bad value still shows up
    // as a marker block in the elaborated hierarchy.
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_wdog_cycles_out_of_range
    end
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(RELEASE_CYCLES);
        tmr_dec  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_req && start_ok) state_d = WAIT_VBL;
            end
            WAIT_VBL: begin
                if (!hs_req) begin
                    state_d = IDLE;
                end else if (vblank) begin
                    state_d = PAUSE;
`ifdef HS_ARB_WDOG_EN
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(WDOG_CYCLES);
`endif
                end
            end
            PAUSE: begin
                if (!hs_req) begin
                    state_d  = RELEASE;
                    tmr_load = 1'b1;
                end else if (cpu_paused) begin
                    state_d = GRANT;
`ifdef HS_ARB_WDOG_EN
                end else if (tmr_tc) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
`endif
                end
            end
            GRANT: begin
                // cpu_paused is deliberately ignored here: once granted,
                // only hs_req ends the transfer.
                if (!hs_req) begin
                    state_d  = RELEASE;
                    tmr_load = 1'b1;
                end
            end
            RELEASE: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode the registered state only, so reset clears them at once.
    assign pause_req = (state_q == PAUSE) || (state_q == GRANT) || (state_q == RELEASE);
    assign hs_grant  = (state_q == GRANT);

    assign ram_addr = hs_grant ? hs_addr : cpu_addr;
    assign ram_din  = hs_grant ? hs_din  : cpu_din;
    assign ram_we   = hs_grant ? hs_we   : cpu_we;

    assign cpu_dout = ram_dout;
    assign hs_dout  = ram_dout;

endmodule
